// File: rtl/nw_traceback.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : nw_traceback                                                     |
// | Brief   : Loads a Needleman-Wunsch score matrix and walks it back from     |
// |           (LENGTH,LENGTH) to (0,0), emitting one alignment op per beat.    |
// |           Macro NW_TB_BOUNDARY_GEN_EN: load interior only, boundary made   |
// |           internally.                                                      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module nw_traceback #(
  parameter int LENGTH   = 10,
  parameter int CWIDTH   = 2,
  parameter int SWIDTH   = 16,
  parameter int MATCH    = 1,
  parameter int INDEL    = -1,
  parameter int MISMATCH = -1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [LENGTH*CWIDTH-1:0] s1,
  input  logic [LENGTH*CWIDTH-1:0] s2,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SWIDTH-1:0]        in_score,
  output logic                     op_valid,
  input  logic                     op_ready,
  output logic [1:0]               op,
  output logic [CWIDTH-1:0]        op_c1,
  output logic [CWIDTH-1:0]        op_c2,
  output logic                     op_last,
  output logic [SWIDTH-1:0]        final_score,
  output logic                     done,
  output logic                     err
);

  localparam int              IW         = $clog2(LENGTH + 1);
  localparam logic [IW-1:0]   c_LAST     = IW'(LENGTH);
`ifdef NW_TB_BOUNDARY_GEN_EN
  localparam logic [IW-1:0]   c_FIRST    = IW'(1);
`else
  localparam logic [IW-1:0]   c_FIRST    = '0;
`endif
  localparam logic [SWIDTH-1:0] c_MATCH  = SWIDTH'(MATCH);
  localparam logic [SWIDTH-1:0] c_MISM   = SWIDTH'(MISMATCH);
  localparam logic [SWIDTH-1:0] c_INDEL  = SWIDTH'(INDEL);
  localparam logic [1:0]      c_OP_MATCH = 2'b00;
  localparam logic [1:0]      c_OP_MISM  = 2'b01;
  localparam logic [1:0]      c_OP_UP    = 2'b10;
  localparam logic [1:0]      c_OP_LEFT  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WALK = 2'd2
  } state_t;

  state_t                    r_state;
  logic [IW-1:0]             r_i;
  logic [IW-1:0]             r_j;
  logic [LENGTH*CWIDTH-1:0]  r_s1;
  logic [LENGTH*CWIDTH-1:0]  r_s2;
  logic [SWIDTH-1:0]         r_final;
  logic                      r_done;
  logic                      r_err;
  logic [SWIDTH-1:0]         r_mem [0:LENGTH][0:LENGTH];

  logic [IW-1:0]             w_im1;
  logic [IW-1:0]             w_jm1;
  logic [SWIDTH-1:0]         w_s;
  logic [SWIDTH-1:0]         w_sd;
  logic [SWIDTH-1:0]         w_su;
  logic [SWIDTH-1:0]         w_sl;
  logic [CWIDTH-1:0]         w_ch1;
  logic [CWIDTH-1:0]         w_ch2;
  logic                      w_eq;
  logic                      w_is_diag;
  logic                      w_is_up;
  logic                      w_is_left;
  logic [1:0]                w_op;
  logic [CWIDTH-1:0]         w_c1;
  logic [CWIDTH-1:0]         w_c2;
  logic [IW-1:0]             w_ni;
  logic [IW-1:0]             w_nj;
  logic                      w_bad;
  logic                      w_last;
  logic                      w_walk;

  // Boundary row/column are synthesised from INDEL when the generator is enabled.
  function automatic logic [SWIDTH-1:0] f_rd(input logic [IW-1:0] a_i, input logic [IW-1:0] a_j);
`ifdef NW_TB_BOUNDARY_GEN_EN
    if (a_i == '0) return c_INDEL * SWIDTH'(a_j);
    if (a_j == '0) return c_INDEL * SWIDTH'(a_i);
`endif
    return r_mem[a_i][a_j];
  endfunction

  always_ff @(posedge clk) begin
    if (!reset && r_state == ST_LOAD && in_valid) begin
      r_mem[r_i][r_j] <= in_score;
    end
  end

  always_comb begin
    w_im1     = (r_i == '0) ? '0 : r_i - IW'(1);
    w_jm1     = (r_j == '0) ? '0 : r_j - IW'(1);
    w_s       = f_rd(r_i, r_j);
    w_sd      = f_rd(w_im1, w_jm1);
    w_su      = f_rd(w_im1, r_j);
    w_sl      = f_rd(r_i, w_jm1);
    w_ch1     = r_s1[w_im1*CWIDTH +: CWIDTH];
    w_ch2     = r_s2[w_jm1*CWIDTH +: CWIDTH];
    w_eq      = (w_ch1 == w_ch2);
    w_is_diag = (w_s == w_sd + (w_eq ? c_MATCH : c_MISM));
    w_is_up   = (w_s == w_su + c_INDEL);
    w_is_left = (w_s == w_sl + c_INDEL);

    w_op  = c_OP_LEFT;
    w_c1  = '0;
    w_c2  = w_ch2;
    w_ni  = r_i;
    w_nj  = w_jm1;
    w_bad = 1'b0;
    if (r_i == '0) begin
      w_op = c_OP_LEFT;
    end else if (r_j == '0) begin
      w_op = c_OP_UP;
      w_c1 = w_ch1;
      w_c2 = '0;
      w_ni = w_im1;
      w_nj = r_j;
    end else if (w_is_diag) begin
      w_op = w_eq ? c_OP_MATCH : c_OP_MISM;
      w_c1 = w_ch1;
      w_ni = w_im1;
    end else if (w_is_up) begin
      w_op = c_OP_UP;
      w_c1 = w_ch1;
      w_c2 = '0;
      w_ni = w_im1;
      w_nj = r_j;
    end else if (!w_is_left) begin
      w_bad = 1'b1;
    end
    w_last = (w_ni == '0) && (w_nj == '0);
  end

  assign w_walk      = (r_state == ST_WALK);
  assign in_ready    = (r_state == ST_LOAD);
  assign op_valid    = w_walk && !w_bad;
  assign op          = w_walk ? w_op : 2'b00;
  assign op_c1       = w_walk ? w_c1 : '0;
  assign op_c2       = w_walk ? w_c2 : '0;
  assign op_last     = w_walk && w_last;
  assign final_score = r_final;
  assign done        = r_done;
  assign err         = r_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_i     <= '0;
      r_j     <= '0;
      r_s1    <= '0;
      r_s2    <= '0;
      r_final <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_s1    <= s1;
            r_s2    <= s2;
            r_err   <= 1'b0;
            r_i     <= c_FIRST;
            r_j     <= c_FIRST;
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (in_valid) begin
            // The last word lands on (LENGTH,LENGTH), which is also the walk start.
            if (r_i == c_LAST && r_j == c_LAST) begin
              r_final <= in_score;
              r_state <= ST_WALK;
            end else if (r_j == c_LAST) begin
              r_j <= c_FIRST;
              r_i <= r_i + IW'(1);
            end else begin
              r_j <= r_j + IW'(1);
            end
          end
        end
        ST_WALK: begin
          if (w_bad) begin
            r_err   <= 1'b1;
            r_state <= ST_IDLE;
          end else if (op_ready) begin
            r_i <= w_ni;
            r_j <= w_nj;
            if (w_last) begin
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nw_traceback.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_nw_traceback                                                  |
// | Brief   : Bench for nw_traceback; builds NW matrices, predicts ops.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_nw_traceback;
  localparam int L  = 4;
  localparam int CW = 2;
  localparam int SW = 16;
  localparam int NC = L + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [L*CW-1:0] s1;
  logic [L*CW-1:0] s2;
  logic          in_valid;
  logic          in_ready;
  logic [SW-1:0] in_score;
  logic          op_valid;
  logic          op_ready;
  logic [1:0]    op;
  logic [CW-1:0] op_c1;
  logic [CW-1:0] op_c2;
  logic          op_last;
  logic [SW-1:0] final_score;
  logic          done;
  logic          err;

  always #5 clk = ~clk;

  nw_traceback #(.LENGTH(L), .CWIDTH(CW), .SWIDTH(SW), .MATCH(1), .INDEL(-1), .MISMATCH(-1)) u_dut (
    .clk(clk), .reset(reset), .start(start), .s1(s1), .s2(s2),
    .in_valid(in_valid), .in_ready(in_ready), .in_score(in_score),
    .op_valid(op_valid), .op_ready(op_ready), .op(op), .op_c1(op_c1), .op_c2(op_c2),
    .op_last(op_last), .final_score(final_score), .done(done), .err(err)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int m [0:L][0:L];
  int e_op[$];
  int e_c1[$];
  int e_c2[$];
  bit e_bad;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int ch(input logic [L*CW-1:0] v, input int k);
    return int'((v >> (k*CW)) & 3);
  endfunction

  // Standard global-alignment fill: best of diagonal, up and left.
  task automatic build(input logic [L*CW-1:0] a, input logic [L*CW-1:0] b);
    for (int i = 0; i <= L; i++) m[i][0] = -i;
    for (int j = 0; j <= L; j++) m[0][j] = -j;
    for (int i = 1; i <= L; i++)
      for (int j = 1; j <= L; j++) begin
        int d, u, lf, best;
        d  = m[i-1][j-1] + ((ch(a, i-1) == ch(b, j-1)) ? 1 : -1);
        u  = m[i-1][j] - 1;
        lf = m[i][j-1] - 1;
        best = d;
        if (u > best) best = u;
        if (lf > best) best = lf;
        m[i][j] = best;
      end
  endtask

  task automatic predict(input logic [L*CW-1:0] a, input logic [L*CW-1:0] b);
    int i, j;
    e_op.delete(); e_c1.delete(); e_c2.delete();
    e_bad = 1'b0;
    i = L; j = L;
    while (i > 0 || j > 0) begin
      if (i == 0) begin
        e_op.push_back(3); e_c1.push_back(0); e_c2.push_back(ch(b, j-1)); j--;
      end else if (j == 0) begin
        e_op.push_back(2); e_c1.push_back(ch(a, i-1)); e_c2.push_back(0); i--;
      end else if (m[i][j] == m[i-1][j-1] + ((ch(a, i-1) == ch(b, j-1)) ? 1 : -1)) begin
        e_op.push_back((ch(a, i-1) == ch(b, j-1)) ? 0 : 1);
        e_c1.push_back(ch(a, i-1)); e_c2.push_back(ch(b, j-1)); i--; j--;
      end else if (m[i][j] == m[i-1][j] - 1) begin
        e_op.push_back(2); e_c1.push_back(ch(a, i-1)); e_c2.push_back(0); i--;
      end else if (m[i][j] == m[i][j-1] - 1) begin
        e_op.push_back(3); e_c1.push_back(0); e_c2.push_back(ch(b, j-1)); j--;
      end else begin
        e_bad = 1'b1;
        break;
      end
    end
  endtask

  task automatic word_rc(input int idx, output int r, output int c);
`ifdef NW_TB_BOUNDARY_GEN_EN
    r = 1 + idx / L; c = 1 + idx % L;
`else
    r = idx / NC; c = idx % NC;
`endif
  endtask

  // mode 0: op_ready high; 1: random; 2: repeating 1-0-0-1
  task automatic run(input logic [L*CW-1:0] a, input logic [L*CW-1:0] b, input bit corrupt, input int mode);
    int nwords, idx, cyc, k, r, c;
    bit hs, rdy, finished;
`ifdef NW_TB_BOUNDARY_GEN_EN
    nwords = L * L;
`else
    nwords = NC * NC;
`endif
    build(a, b);
    if (corrupt) m[L][L] = m[L][L] + 5;
    predict(a, b);

    @(negedge clk);
    s1 = a; s2 = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("err_cleared", err, 0);
    chk("in_ready_load", in_ready, 1);

    idx = 0; cyc = 0;
    while (idx < nwords && cyc < 500) begin
      word_rc(idx, r, c);
      in_valid = ($urandom_range(3) != 0);
      in_score = SW'(m[r][c]);
      start    = ($urandom_range(7) == 0);
      hs = in_ready && in_valid;
      @(negedge clk);
      cyc++;
      if (hs) idx++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    chk("load_count", idx, nwords);
    chk("in_ready_walk", in_ready, 0);
    chk("final_score", int'($signed(final_score)), m[L][L]);

    k = 0; cyc = 0; finished = 1'b0;
    while (cyc < 200) begin
      if (e_bad && k == e_op.size()) begin
        chk("bad_op_valid", op_valid, 0);
        op_ready = 1'b1;
        @(negedge clk);
        chk("err_set", err, 1);
        chk("bad_idle", {in_ready, op_valid, done}, 0);
        @(negedge clk);
        chk("bad_no_done", done, 0);
        chk("err_sticky", err, 1);
        finished = 1'b1;
        break;
      end
      chk("op_valid", op_valid, 1);
      chk("op", op, e_op[k]);
      chk("op_c1", op_c1, e_c1[k]);
      chk("op_c2", op_c2, e_c2[k]);
      chk("op_last", op_last, (k == e_op.size() - 1) ? 1 : 0);
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ($urandom_range(2) != 0);
        default: rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
      endcase
      op_ready = rdy;
      @(negedge clk);
      cyc++;
      if (rdy) begin
        k++;
        if (k == e_op.size() && !e_bad) begin
          chk("done_pulse", done, 1);
          chk("idle_after", op_valid, 0);
          chk("no_err", err, 0);
          @(negedge clk);
          chk("done_low", done, 0);
          finished = 1'b1;
          break;
        end
      end
    end
    op_ready = 1'b0;
    chk("walk_finished", finished, 1);
  endtask

  initial begin
    logic [L*CW-1:0] ra, rb;
    int r, c;
    reset = 1'b1; start = 1'b0; s1 = '0; s2 = '0;
    in_valid = 1'b0; in_score = '0; op_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_op_valid", op_valid, 0);
    chk("rst_outs", {op, op_c1, op_c2, op_last, done, err}, 0);
    chk("rst_final", final_score, 0);

    run({2'd3, 2'd2, 2'd1, 2'd0}, {2'd3, 2'd2, 2'd1, 2'd0}, 1'b0, 0);
    chk("s1_final", int'($signed(final_score)), 4);
    run({2'd3, 2'd2, 2'd1, 2'd0}, {2'd3, 2'd3, 2'd1, 2'd0}, 1'b0, 0);
    chk("s2_final", int'($signed(final_score)), 2);
    run({2'd0, 2'd0, 2'd0, 2'd0}, {2'd1, 2'd1, 2'd1, 2'd1}, 1'b0, 0);
    chk("s3_final", int'($signed(final_score)), -4);
    run({2'd3, 2'd2, 2'd1, 2'd0}, {2'd3, 2'd3, 2'd1, 2'd0}, 1'b0, 2);
    run({2'd3, 2'd2, 2'd1, 2'd0}, {2'd3, 2'd2, 2'd1, 2'd0}, 1'b1, 0);
    run({2'd3, 2'd2, 2'd1, 2'd0}, {2'd3, 2'd2, 2'd1, 2'd0}, 1'b0, 1);

    // Abort a load with reset, then redo the first scenario.
    build({2'd3, 2'd2, 2'd1, 2'd0}, {2'd3, 2'd2, 2'd1, 2'd0});
    @(negedge clk);
    s1 = {2'd3, 2'd2, 2'd1, 2'd0}; s2 = s1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 7; n++) begin
      word_rc(n, r, c);
      in_valid = 1'b1; in_score = SW'(m[r][c]);
      @(negedge clk);
    end
    in_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_in_ready", in_ready, 0);
    chk("abort_outs", {op_valid, done, err}, 0);
    chk("abort_final", final_score, 0);
    run({2'd3, 2'd2, 2'd1, 2'd0}, {2'd3, 2'd2, 2'd1, 2'd0}, 1'b0, 0);
    chk("abort_redo_final", int'($signed(final_score)), 4);

    for (int t = 0; t < 8; t++) begin
      ra = L*CW'($urandom);
      rb = L*CW'($urandom);
      run(ra, rb, 1'b0, 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
